wbapb_bridge: RTL
=================

Name: wbapb_bridge

Overview:
Pipelined-Wishbone slave to APB4 master bridge; converts one Wishbone request at a time into a protocol-correct APB SETUP/ACCESS transfer. Sits directly upstream of any APB slave on the peripheral bus and drives PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB. It returns PRDATA and PSLVERR to the Wishbone master as ACK/ERR.

Parameters:
AW, 30, Wishbone word-address width; APB byte address is AW+2 bits
DW, 32, data width (8, 16, 32, 64 or 128)
OPT_LOWPOWER, 1'b0, when set, APB address/data/strobe outputs are zeroed whenever PSEL is low

Ports:
i_clk  in  1  clock, all logic rising-edge
i_reset  in  1  synchronous, active-high reset
i_wb_cyc  in  1  Wishbone bus cycle
i_wb_stb  in  1  Wishbone request strobe
i_wb_we  in  1  write enable
i_wb_addr  in  AW  word address
i_wb_data  in  DW  write data
i_wb_sel  in  DW/8  byte selects
o_wb_stall  out  1  request not accepted this cycle
o_wb_ack  out  1  successful completion, one-cycle pulse
o_wb_data  out  DW  read data, valid with o_wb_ack
o_wb_err  out  1  error completion, one-cycle pulse
o_apb_psel  out  1  PSEL
o_apb_penable  out  1  PENABLE
o_apb_paddr  out  AW+2  PADDR = {addr, 2'b00} for DW=32; low log2(DW/8) bits always zero
o_apb_pwrite  out  1  PWRITE
o_apb_pwdata  out  DW  PWDATA
o_apb_pstrb  out  DW/8  PSTRB; i_wb_sel on writes, all-zero on reads
i_apb_pready  in  1  PREADY
i_apb_prdata  in  DW  PRDATA
i_apb_pslverr  in  1  PSLVERR

Behaviour:
- States: IDLE, SETUP, ACCESS. All outputs registered.
- Reset (sync, i_reset=1): state=IDLE; psel=penable=0; ack=err=0; stall=0; o_wb_data=0; APB addr/data/strb=0. Reset mid-transfer drops PSEL/PENABLE on the next edge. No ack or err is ever issued for the aborted transfer.
- o_wb_stall = (state != IDLE). Exactly one outstanding request.
- IDLE: if i_wb_cyc && i_wb_stb, latch addr/we/data/sel into the APB outputs. Go to SETUP: psel=1, penable=0. Requests with i_wb_cyc=0 are ignored.
- SETUP: always go to ACCESS next cycle (penable=1). PADDR/PWRITE/PWDATA/PSTRB do not change.
- ACCESS: hold all APB outputs stable while !i_apb_pready; there is no timeout.
- ACCESS completion: on i_apb_pready=1, the next cycle has psel=0, penable=0 and state=IDLE. In that same cycle:
  - o_wb_ack = !i_apb_pslverr
  - o_wb_err = i_apb_pslverr
  - o_wb_data = i_apb_prdata, captured on reads only; on writes o_wb_data holds its prior value, or 0 if OPT_LOWPOWER.
- i_apb_pslverr and i_apb_prdata are sampled only when psel && penable && pready.
- ack and err are never both high, and each is high for exactly one cycle.
- Latency with a zero-wait slave: stb accepted at cycle 0, SETUP at 1, ACCESS at 2, ack at 3. A new request can be accepted at cycle 3 (stall=0 there). Each wait state adds one cycle.
- Abort: if i_wb_cyc falls at any point after acceptance, the APB transfer still runs to PREADY (APB cannot abort). The ack/err for it is suppressed via an abort flag; the flag clears on return to IDLE.
- A new cycle raised while an aborted transfer drains sees stall=1 until IDLE.
- PENABLE is never high without PSEL. PSEL never rises together with PENABLE. Between transfers there is always at least one cycle with PSEL=0.
- OPT_LOWPOWER=1: paddr/pwdata/pstrb/pwrite are forced to 0 in IDLE, and o_wb_data is 0 except in the ack cycle.

Test Plan:
- Write, zero-wait: addr=0x10, data=0xDEADBEEF, sel=4'hF -> psel at cycle 1, penable at cycle 2, PADDR=0x40, PSTRB=F; o_wb_ack=1 at cycle 3; stall low again at cycle 3.
- Read, 3 wait states, PRDATA=0x12345678 -> APB outputs stable for 3 cycles; ack at cycle 6 with o_wb_data=0x12345678; PSTRB=0 throughout.
- PSLVERR=1 on a write completion -> o_wb_err=1 and o_wb_ack=0 for one cycle; the bridge returns to IDLE.
- i_wb_cyc dropped during a 2-wait-state ACCESS -> APB transfer completes normally; no ack/err; a new request is accepted the cycle after PSEL falls.
- i_reset asserted during ACCESS -> psel=penable=0 on the next edge; no ack; the following request runs a normal SETUP/ACCESS.
- Back-to-back stb held high for 4 requests against a zero-wait slave -> 4 acks spaced 3 cycles apart; PSEL low for ≥1 cycle between transfers; formal APB slave properties pass.

Source files
------------

// File: rtl/wbapb_bridge.sv
// ---------------------------------------------------------------------------
// wbapb_bridge
//   Pipelined Wishbone slave to APB4 master bridge. One Wishbone request is
//   accepted at a time and replayed on APB as a SETUP phase followed by an
//   ACCESS phase that lasts until PREADY. PRDATA/PSLVERR come back to the
//   Wishbone master as a single-cycle ACK or ERR.
//
// Ports
//   i_clk, i_reset          clock (rising edge), synchronous active-high reset
//   i_wb_cyc/stb/we         Wishbone cycle, strobe, write enable
//   i_wb_addr/data/sel      Wishbone word address, write data, byte selects
//   o_wb_stall              high while a transfer is outstanding
//   o_wb_ack/err            one-cycle completion pulses (never both)
//   o_wb_data               read data, valid with o_wb_ack
//   o_apb_psel/penable      APB phase control
//   o_apb_paddr             APB byte address (word address shifted left)
//   o_apb_pwrite/pwdata     APB direction and write data
//   o_apb_pstrb             APB byte strobes (zero on reads)
//   i_apb_pready/prdata/pslverr  APB slave response
//
// wbapb_bridge_checker
//   Non-synthesised companion holding the APB/Wishbone handshake assertions.
// ---------------------------------------------------------------------------
module wbapb_bridge #(
    parameter int   AW           = 30,
    parameter int   DW           = 32,
    parameter logic OPT_LOWPOWER = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [AW-1:0]     i_wb_addr,
    input  logic [DW-1:0]     i_wb_data,
    input  logic [DW/8-1:0]   i_wb_sel,
    output logic              o_wb_stall,
    output logic              o_wb_ack,
    output logic [DW-1:0]     o_wb_data,
    output logic              o_wb_err,
    output logic              o_apb_psel,
    output logic              o_apb_penable,
    output logic [AW+1:0]     o_apb_paddr,
    output logic              o_apb_pwrite,
    output logic [DW-1:0]     o_apb_pwdata,
    output logic [DW/8-1:0]   o_apb_pstrb,
    input  logic              i_apb_pready,
    input  logic [DW-1:0]     i_apb_prdata,
    input  logic              i_apb_pslverr
);

    localparam int SW       = DW / 8;
    // Byte-address offset of one bus word (2 for a 32-bit bus).
    localparam int ADDR_LSB = $clog2(SW);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t state_r;
    // Set when the Wishbone master abandons the cycle after acceptance; the
    // APB side still finishes but the completion pulse is swallowed.
    logic   abort_r;

    // Bridge FSM: owns every output register and the abort flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r       <= ST_IDLE;
            abort_r       <= 1'b0;
            o_wb_stall    <= 1'b0;
            o_wb_ack      <= 1'b0;
            o_wb_err      <= 1'b0;
            o_wb_data     <= {DW{1'b0}};
            o_apb_psel    <= 1'b0;
            o_apb_penable <= 1'b0;
            o_apb_paddr   <= {(AW+2){1'b0}};
            o_apb_pwrite  <= 1'b0;
            o_apb_pwdata  <= {DW{1'b0}};
            o_apb_pstrb   <= {SW{1'b0}};
        end else begin
            // Completion pulses last exactly one cycle.
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            if (OPT_LOWPOWER) begin
                o_wb_data <= {DW{1'b0}};
            end

            case (state_r)
                ST_IDLE: begin
                    if (i_wb_cyc && i_wb_stb) begin
                        state_r       <= ST_SETUP;
                        abort_r       <= 1'b0;
                        o_wb_stall    <= 1'b1;
                        o_apb_psel    <= 1'b1;
                        o_apb_penable <= 1'b0;
                        o_apb_paddr   <= {2'b00, i_wb_addr} << ADDR_LSB;
                        o_apb_pwrite  <= i_wb_we;
                        o_apb_pwdata  <= i_wb_data;
                        o_apb_pstrb   <= i_wb_we ? i_wb_sel : {SW{1'b0}};
                    end
                end

                ST_SETUP: begin
                    state_r       <= ST_ACCESS;
                    o_apb_penable <= 1'b1;
                    if (!i_wb_cyc) begin
                        abort_r <= 1'b1;
                    end
                end

                ST_ACCESS: begin
                    if (i_apb_pready) begin
                        state_r       <= ST_IDLE;
                        abort_r       <= 1'b0;
                        o_wb_stall    <= 1'b0;
                        o_apb_psel    <= 1'b0;
                        o_apb_penable <= 1'b0;
                        // A cycle dropped in this very cycle also counts as
                        // an abort, not only one dropped earlier.
                        if (!abort_r && i_wb_cyc) begin
                            o_wb_ack <= !i_apb_pslverr;
                            o_wb_err <= i_apb_pslverr;
                            if (!o_apb_pwrite) begin
                                o_wb_data <= i_apb_prdata;
                            end
                        end
                        if (OPT_LOWPOWER) begin
                            o_apb_paddr  <= {(AW+2){1'b0}};
                            o_apb_pwrite <= 1'b0;
                            o_apb_pwdata <= {DW{1'b0}};
                            o_apb_pstrb  <= {SW{1'b0}};
                        end
                    end else if (!i_wb_cyc) begin
                        abort_r <= 1'b1;
                    end
                end

                default: begin
                    state_r       <= ST_IDLE;
                    abort_r       <= 1'b0;
                    o_wb_stall    <= 1'b0;
                    o_apb_psel    <= 1'b0;
                    o_apb_penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

module wbapb_bridge_checker #(
    parameter int AW = 30,
    parameter int DW = 32
) (
    input logic              i_clk,
    input logic              i_reset,
    input logic              psel,
    input logic              penable,
    input logic              pready,
    input logic [AW+1:0]     paddr,
    input logic              pwrite,
    input logic [DW-1:0]     pwdata,
    input logic [DW/8-1:0]   pstrb,
    input logic              ack,
    input logic              err
);

    logic              prev_psel_r;
    logic              prev_hold_r;
    logic              prev_ack_r;
    logic              prev_err_r;
    logic [AW+1:0]     prev_paddr_r;
    logic              prev_pwrite_r;
    logic [DW-1:0]     prev_pwdata_r;
    logic [DW/8-1:0]   prev_pstrb_r;

    // Snapshot of the bus one edge back; a wait-state hold is only
    // remembered when no reset was applied at that edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prev_psel_r   <= 1'b0;
            prev_hold_r   <= 1'b0;
            prev_ack_r    <= 1'b0;
            prev_err_r    <= 1'b0;
            prev_paddr_r  <= {(AW+2){1'b0}};
            prev_pwrite_r <= 1'b0;
            prev_pwdata_r <= {DW{1'b0}};
            prev_pstrb_r  <= {(DW/8){1'b0}};
        end else begin
            prev_psel_r   <= psel;
            prev_hold_r   <= psel && penable && !pready;
            prev_ack_r    <= ack;
            prev_err_r    <= err;
            prev_paddr_r  <= paddr;
            prev_pwrite_r <= pwrite;
            prev_pwdata_r <= pwdata;
            prev_pstrb_r  <= pstrb;
        end
    end

    // Handshake rules evaluated mid-cycle, away from the active edge.
    always @(negedge i_clk) begin
        assert (!(penable && !psel)) else $error("penable high without psel");
        assert (!(ack && err)) else $error("ack and err together");
        assert (!(ack && prev_ack_r)) else $error("ack longer than one cycle");
        assert (!(err && prev_err_r)) else $error("err longer than one cycle");
        assert (!(psel && !prev_psel_r && penable)) else $error("psel rose with penable");
        if (prev_hold_r) begin
            assert (psel && penable) else $error("access phase dropped before pready");
            assert (paddr == prev_paddr_r) else $error("paddr changed in wait state");
            assert (pwrite == prev_pwrite_r) else $error("pwrite changed in wait state");
            assert (pwdata == prev_pwdata_r) else $error("pwdata changed in wait state");
            assert (pstrb == prev_pstrb_r) else $error("pstrb changed in wait state");
        end
    end

endmodule
